// File: rtl/axi_mem_model_rw.sv
// AXI4 slave memory model with independent write (AW/W/B) and read (AR/R)
// channels, FIXED/INCR/WRAP bursts, byte strobes and beat counters.
module axi_mem_model_rw #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 128,
    parameter int                    ID_WIDTH     = 4,
    parameter int                    MEM_DEPTH    = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = {DATA_WIDTH/32{32'hDEADBEEF}},
    parameter int                    TIMEOUT      = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic [31:0]             wr_beat_cnt,
    output logic [31:0]             rd_beat_cnt
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    // Backing store: starts at the fill pattern and is never cleared by rst
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: FILL_PATTERN};

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> SZ) < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> SZ);
    endfunction

    function automatic logic is_legal(
        input logic [2:0] size,
        input logic [7:0] len,
        input logic [1:0] burst
    );
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                  (len == 8'd7) || (len == 8'd15);
        return (size == 3'(SZ)) && (burst != 2'b11) &&
               ((burst != BURST_WRAP) || wrap_ok);
    endfunction

    // Address of the beat following the one at address a
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] al;
        logic [ADDR_WIDTH-1:0] span;
        logic [ADDR_WIDTH-1:0] bound;
        logic [ADDR_WIDTH-1:0] nxt;
        al    = a & ~ADDR_WIDTH'(BYTES - 1);
        span  = ADDR_WIDTH'((32'(len) + 32'd1) * 32'(BYTES));
        bound = a & ~(span - ADDR_WIDTH'(1));
        nxt   = al + ADDR_WIDTH'(BYTES);
        if (burst == BURST_FIXED) begin
            return a;
        end
        if ((burst == BURST_WRAP) && (nxt == bound + span)) begin
            return bound;
        end
        return nxt;
    endfunction

    // ---------------- write channel ----------------
    logic [1:0]            w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [1:0]            w_burst;
    logic [7:0]            w_beat;
    logic                  w_ok;
    logic                  w_slv;
    logic                  w_dec;
    logic [31:0]           w_idle;

    logic                  w_fire;
    logic                  w_final;
    logic                  w_hit;
    logic                  w_slv_n;
    logic                  w_dec_n;
    logic [1:0]            w_resp_n;

    // Per-beat error accumulation for the write burst in flight
    always_comb begin
        w_fire   = wvalid & wready;
        w_final  = (w_beat == w_len);
        w_hit    = in_range(w_addr);
        w_dec_n  = w_dec | ~w_hit;
        w_slv_n  = w_slv | ~w_ok | (wlast != w_final);
        w_resp_n = w_dec_n ? RESP_DECERR :
                   w_slv_n ? RESP_SLVERR : RESP_OKAY;
    end

    // Write FSM: accept AW, take beats until beat == len or timeout, hold B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_ok    <= 1'b0;
            w_slv   <= 1'b0;
            w_dec   <= 1'b0;
            w_idle  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_id    <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_burst <= awburst;
                        w_ok    <= is_legal(awsize, awlen, awburst);
                        w_beat  <= '0;
                        w_slv   <= 1'b0;
                        w_dec   <= 1'b0;
                        w_idle  <= '0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idle <= '0;
                        w_beat <= w_beat + 8'd1;
                        w_addr <= next_addr(w_addr, w_len, w_burst);
                        w_slv  <= w_slv_n;
                        w_dec  <= w_dec_n;
                        if (w_final) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= w_resp_n;
                            w_state <= W_RESP;
                        end
                    end else if (w_idle == 32'(TIMEOUT - 1)) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bid     <= w_id;
                        bresp   <= w_dec ? RESP_DECERR : RESP_SLVERR;
                        w_state <= W_RESP;
                    end else begin
                        w_idle <= w_idle + 32'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Commit strobed bytes of a legal, in-range write beat
    always_ff @(posedge clk) begin
        if (w_fire && w_ok && w_hit) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Saturating count of accepted write beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_beat_cnt <= '0;
        end else if (w_fire && (wr_beat_cnt != 32'hFFFF_FFFF)) begin
            wr_beat_cnt <= wr_beat_cnt + 32'd1;
        end
    end

    // ---------------- read channel ----------------
    logic                  r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [1:0]            r_burst;
    logic [7:0]            r_beat;
    logic                  r_ok;

    logic                  r_fire;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_ok;
    logic                  ld_hit;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [1:0]            ld_resp;

    // Data and response of the beat loaded at the next edge
    always_comb begin
        r_fire  = rvalid & rready;
        ld_addr = (r_state == R_IDLE) ? araddr : r_addr;
        ld_ok   = (r_state == R_IDLE) ? is_legal(arsize, arlen, arburst) : r_ok;
        ld_hit  = in_range(ld_addr);
        ld_data = (ld_ok && ld_hit) ? mem[word_idx(ld_addr)] : '0;
        ld_resp = !ld_hit ? RESP_DECERR :
                  !ld_ok  ? RESP_SLVERR : RESP_OKAY;
    end

    // Read FSM: present registered beats back to back until rlast is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_ok    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_len   <= arlen;
                        r_burst <= arburst;
                        r_ok    <= ld_ok;
                        r_addr  <= next_addr(araddr, arlen, arburst);
                        r_beat  <= '0;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        rdata   <= ld_data;
                        rresp   <= ld_resp;
                        rlast   <= (arlen == 8'd0);
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rdata  <= ld_data;
                            rresp  <= ld_resp;
                            rlast  <= ((r_beat + 8'd1) == r_len);
                            r_beat <= r_beat + 8'd1;
                            r_addr <= next_addr(r_addr, r_len, r_burst);
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // Saturating count of accepted read beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_beat_cnt <= '0;
        end else if (r_fire && (rd_beat_cnt != 32'hFFFF_FFFF)) begin
            rd_beat_cnt <= rd_beat_cnt + 32'd1;
        end
    end

endmodule
